// File: rtl/game_event_ctrl.sv
// Game event controller: key/gameplay decode, request handshake to state_fsm,
// lives counter and level timer. Optional pause key under `PAUSE_KEY_EN.
module game_event_ctrl #(
  parameter int          LIVES         = 3,
  parameter int          TIME_LIMIT    = 300,
  parameter int          TICKS_PER_SEC = 60,
  parameter int          INVULN_TICKS  = 120,
  parameter logic [7:0]  KEY_START     = 8'h29,
  parameter logic [7:0]  KEY_RESTART   = 8'h2D,
  parameter logic [7:0]  KEY_PAUSE     = 8'h4D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       tick,
  input  logic       hit,
  input  logic       fall,
  input  logic       goal,
  output logic       start,
  output logic       restart,
  output logic       over,
  output logic       success,
  output logic [2:0] lives,
  output logic [8:0] time_left,
  output logic       invuln,
  output logic       paused
);

  localparam int PW = $clog2(TICKS_PER_SEC + 1);
  localparam int IW = $clog2(INVULN_TICKS + 1);
  localparam logic [2:0]    LIVES_V = 3'(LIVES);
  localparam logic [8:0]    TIME_V  = 9'(TIME_LIMIT);
  localparam logic [PW-1:0] PS_TOP  = PW'(TICKS_PER_SEC - 1);
  localparam logic [IW-1:0] IMM_V   = IW'(INVULN_TICKS);

  typedef enum logic {WAIT, RUN} mode_e;

  mode_e         mode_q, mode_d;
  logic          start_q, start_d;
  logic          restart_q, restart_d;
  logic          over_q, over_d;
  logic          success_q, success_d;
  logic [2:0]    lives_q, lives_d;
  logic [8:0]    time_q, time_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [IW-1:0] imm_q, imm_d;
  logic          inv_q, inv_d;
  logic          hit_q, hit_d;

  logic s_idle, s_play, s_over, s_succ;
  logic pending, run, act, life_loss;

  assign s_idle = (state == 2'b00);
  assign s_play = (state == 2'b01);
  assign s_over = (state == 2'b10);
  assign s_succ = (state == 2'b11);

  assign pending = start_q | restart_q | over_q | success_q;
  assign run = (mode_q == RUN) && s_play && !pending;
  assign life_loss = fall || (hit && !hit_q && !inv_q);

`ifdef PAUSE_KEY_EN
  logic paused_q, paused_d;

  assign act = run && !paused_q;

  // Pause toggles on its key while running, and clears once play ends.
  always_comb begin
    paused_d = paused_q;
    if (!s_play)
      paused_d = 1'b0;
    else if (run && key_valid && key_code == KEY_PAUSE)
      paused_d = !paused_q;
  end

  // Pause register.
  always_ff @(posedge clk) begin
    if (rst) paused_q <= 1'b0;
    else     paused_q <= paused_d;
  end

  assign paused = paused_q;
`else
  logic unused_pause_key;

  assign unused_pause_key = (key_code == KEY_PAUSE);
  assign act = run;
  assign paused = 1'b0;
`endif

  // Next state: handshake, reloads on ack, and gameplay updates in RUN.
  always_comb begin
    start_d   = start_q;
    restart_d = restart_q;
    over_d    = over_q;
    success_d = success_q;
    lives_d   = lives_q;
    time_d    = time_q;
    ps_d      = ps_q;
    imm_d     = imm_q;
    inv_d     = inv_q;
    hit_d     = hit;

    if (start_q && s_play)   start_d   = 1'b0;
    if (restart_q && s_idle) restart_d = 1'b0;
    if (over_q && s_over)    over_d    = 1'b0;
    if (success_q && s_succ) success_d = 1'b0;

    if (!pending && key_valid) begin
      if (key_code == KEY_START && s_idle)
        start_d = 1'b1;
      if (key_code == KEY_RESTART && (s_over || s_succ))
        restart_d = 1'b1;
    end

    if ((start_q && s_play) || (restart_q && s_idle)) begin
      lives_d = LIVES_V;
      time_d  = TIME_V;
      ps_d    = '0;
      imm_d   = '0;
      inv_d   = 1'b0;
    end

    if (act) begin
      if (goal) begin
        success_d = 1'b1;
      end else if (life_loss) begin
        if (lives_q == 3'd1) begin
          lives_d = 3'd0;
          over_d  = 1'b1;
        end else begin
          lives_d = lives_q - 3'd1;
          inv_d   = 1'b1;
          imm_d   = IMM_V;
        end
      end else if (tick) begin
        if (ps_q == PS_TOP) begin
          ps_d = '0;
          if (time_q == 9'd1) begin
            time_d = 9'd0;
            over_d = 1'b1;
          end else if (time_q != 9'd0) begin
            time_d = time_q - 9'd1;
          end
        end else begin
          ps_d = ps_q + PW'(1);
        end
        if (imm_q != '0) begin
          imm_d = imm_q - IW'(1);
          if (imm_q == IW'(1)) inv_d = 1'b0;
        end
      end
    end

    mode_d = (s_play && !(start_d | restart_d | over_d | success_d))
           ? RUN : WAIT;
  end

  // State registers; reset dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= WAIT;
      start_q   <= 1'b0;
      restart_q <= 1'b0;
      over_q    <= 1'b0;
      success_q <= 1'b0;
      lives_q   <= LIVES_V;
      time_q    <= TIME_V;
      ps_q      <= '0;
      imm_q     <= '0;
      inv_q     <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      start_q   <= start_d;
      restart_q <= restart_d;
      over_q    <= over_d;
      success_q <= success_d;
      lives_q   <= lives_d;
      time_q    <= time_d;
      ps_q      <= ps_d;
      imm_q     <= imm_d;
      inv_q     <= inv_d;
      hit_q     <= hit_d;
    end
  end

  assign start     = start_q;
  assign restart   = restart_q;
  assign over      = over_q;
  assign success   = success_q;
  assign lives     = lives_q;
  assign time_left = time_q;
  assign invuln    = inv_q;

endmodule

// File: tb/tb_game_event_ctrl.sv
// Directed bench for game_event_ctrl with shrunk timing parameters.
// Vector table for the main flow plus hand sequences for reset and pause.
module tb_game_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic       key_valid;
  logic [7:0] key_code;
  logic       tick, hit, fall, goal;
  logic       start, restart, over, success;
  logic [2:0] lives;
  logic [8:0] time_left;
  logic       invuln, paused;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  game_event_ctrl #(
    .LIVES(3), .TIME_LIMIT(2), .TICKS_PER_SEC(2), .INVULN_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .state(state),
    .key_valid(key_valid), .key_code(key_code),
    .tick(tick), .hit(hit), .fall(fall), .goal(goal),
    .start(start), .restart(restart), .over(over), .success(success),
    .lives(lives), .time_left(time_left),
    .invuln(invuln), .paused(paused)
  );

  typedef struct {
    logic [1:0] st;
    logic [7:0] kc;
    logic       tk, ht, fl, gl;
    logic [3:0] req;
    logic [2:0] lv;
    logic [8:0] tl;
    logic       iv;
  } vec_t;

  vec_t tbl[40];
  int   nv = 0;

  task automatic add(input logic [1:0] st, input logic [7:0] kc,
                     input logic tk, input logic ht,
                     input logic fl, input logic gl,
                     input logic [3:0] req, input logic [2:0] lv,
                     input logic [8:0] tl, input logic iv);
    tbl[nv] = '{st, kc, tk, ht, fl, gl, req, lv, tl, iv};
    nv++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] reqs();
    return {start, restart, over, success};
  endfunction

  task automatic idle_in();
    key_valid = 0; key_code = 0;
    tick = 0; hit = 0; fall = 0; goal = 0;
  endtask

  initial begin
    int n;
    rst = 1; state = 2'b00;
    idle_in();
    step(); step();
    chk("rst_req", 16'(reqs()), 16'h0);
    chk("rst_lives", 16'(lives), 16'd3);
    chk("rst_time", 16'(time_left), 16'd2);
    chk("rst_inv", 16'(invuln), 16'd0);
    chk("rst_paused", 16'(paused), 16'd0);
    rst = 0;

    //  st     key    tk ht fl gl  req      lv tl iv
    add(2'b00, 8'h00, 0, 0, 0, 0, 4'b0000, 3, 2, 0);
    add(2'b00, 8'h29, 0, 0, 0, 0, 4'b1000, 3, 2, 0);
    add(2'b00, 8'h00, 0, 0, 0, 0, 4'b1000, 3, 2, 0);
    add(2'b01, 8'h00, 0, 0, 0, 0, 4'b0000, 3, 2, 0);
    add(2'b01, 8'h00, 1, 0, 0, 0, 4'b0000, 3, 2, 0);
    add(2'b01, 8'h00, 1, 0, 0, 0, 4'b0000, 3, 1, 0);
    add(2'b01, 8'h00, 1, 0, 0, 0, 4'b0000, 3, 1, 0);
    add(2'b01, 8'h00, 1, 0, 0, 0, 4'b0010, 3, 0, 0);
    add(2'b01, 8'h00, 0, 0, 0, 0, 4'b0010, 3, 0, 0);
    add(2'b10, 8'h00, 0, 0, 0, 0, 4'b0000, 3, 0, 0);
    add(2'b10, 8'h2D, 0, 0, 0, 0, 4'b0100, 3, 0, 0);
    add(2'b00, 8'h00, 0, 0, 0, 0, 4'b0000, 3, 2, 0);
    add(2'b00, 8'h29, 0, 0, 0, 0, 4'b1000, 3, 2, 0);
    add(2'b01, 8'h00, 0, 0, 0, 0, 4'b0000, 3, 2, 0);
    add(2'b01, 8'h00, 0, 1, 0, 0, 4'b0000, 2, 2, 1);
    add(2'b01, 8'h2D, 0, 0, 0, 0, 4'b0000, 2, 2, 1);
    add(2'b01, 8'h00, 0, 1, 0, 0, 4'b0000, 2, 2, 1);
    add(2'b01, 8'h00, 0, 0, 1, 0, 4'b0000, 1, 2, 1);
    add(2'b01, 8'h00, 0, 1, 1, 1, 4'b0001, 1, 2, 1);
    add(2'b01, 8'h00, 0, 0, 0, 0, 4'b0001, 1, 2, 1);
    add(2'b11, 8'h00, 0, 0, 0, 0, 4'b0000, 1, 2, 1);
    add(2'b11, 8'h2D, 0, 0, 0, 0, 4'b0100, 1, 2, 1);
    add(2'b00, 8'h00, 0, 0, 0, 0, 4'b0000, 3, 2, 0);
    add(2'b00, 8'h29, 0, 0, 0, 0, 4'b1000, 3, 2, 0);
    add(2'b01, 8'h00, 0, 0, 0, 0, 4'b0000, 3, 2, 0);
    add(2'b01, 8'h00, 0, 1, 0, 0, 4'b0000, 2, 2, 1);
    add(2'b01, 8'h00, 1, 0, 0, 0, 4'b0000, 2, 2, 1);
    add(2'b01, 8'h00, 1, 0, 0, 0, 4'b0000, 2, 1, 1);
    add(2'b01, 8'h00, 1, 0, 0, 0, 4'b0000, 2, 1, 0);
    add(2'b01, 8'h00, 0, 1, 0, 0, 4'b0000, 1, 1, 1);
    add(2'b01, 8'h00, 0, 0, 1, 0, 4'b0010, 0, 1, 1);
    add(2'b10, 8'h00, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
    add(2'b10, 8'h29, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
    add(2'b10, 8'h2D, 0, 0, 0, 0, 4'b0100, 0, 1, 1);
    add(2'b00, 8'h00, 0, 0, 0, 0, 4'b0000, 3, 2, 0);

    for (int i = 0; i < nv; i++) begin
      state     = tbl[i].st;
      key_valid = (tbl[i].kc != 8'h00);
      key_code  = tbl[i].kc;
      tick = tbl[i].tk; hit = tbl[i].ht;
      fall = tbl[i].fl; goal = tbl[i].gl;
      step();
      chk($sformatf("v%0d_req", i), 16'(reqs()), 16'(tbl[i].req));
      chk($sformatf("v%0d_lives", i), 16'(lives), 16'(tbl[i].lv));
      chk($sformatf("v%0d_time", i), 16'(time_left), 16'(tbl[i].tl));
      chk($sformatf("v%0d_inv", i), 16'(invuln), 16'(tbl[i].iv));
    end
    idle_in();

    // Reset while a start request is pending.
    state = 2'b00; key_valid = 1; key_code = 8'h29;
    step();
    chk("pend_start", 16'(start), 16'd1);
    idle_in(); rst = 1;
    step();
    chk("mid_rst_req", 16'(reqs()), 16'h0);
    chk("mid_rst_lives", 16'(lives), 16'd3);
    chk("mid_rst_time", 16'(time_left), 16'd2);
    rst = 0; key_valid = 1; key_code = 8'h2D;
    step();
    idle_in();
    step();
    chk("idle_restart_key", 16'(reqs()), 16'h0);

    // Enter play, exercise the pause key.
    key_valid = 1; key_code = 8'h29;
    step();
    idle_in(); state = 2'b01;
    step();
    chk("play_req", 16'(reqs()), 16'h0);
    key_valid = 1; key_code = 8'h4D;
    step();
    idle_in();
`ifdef PAUSE_KEY_EN
    chk("pause_on", 16'(paused), 16'd1);
    tick = 1; hit = 1;
    step();
    tick = 1; hit = 0; fall = 1;
    step();
    idle_in();
    chk("pause_time", 16'(time_left), 16'd2);
    chk("pause_lives", 16'(lives), 16'd3);
    key_valid = 1; key_code = 8'h4D;
    step();
    idle_in();
    chk("pause_off", 16'(paused), 16'd0);
`else
    chk("pause_absent", 16'(paused), 16'd0);
    step();
    chk("pause_absent2", 16'(paused), 16'd0);
`endif

    // Count ticks until the timer forces game over, with a budget.
    n = 0;
    tick = 1;
    while (!over && n < 16) begin
      step();
      n++;
    end
    tick = 0;
    chk("timeout_ticks", 16'(n), 16'd4);
    chk("timeout_time", 16'(time_left), 16'd0);
    state = 2'b10;
    step();
    chk("over_ack", 16'(over), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_event_ctrl.md
Name: game_event_ctrl

Overview:
- Generates the `start`, `restart`, `over` and `success` request levels consumed by `state_fsm`.
- Reads `state_fsm`'s `state[1:0]` back as the acknowledge, so it forms the opposite end of that interface.
- Decodes keyboard scancodes and gameplay events (enemy hit, pit fall, goal flag).
- Maintains the lives counter and the level countdown timer shown by the HUD.

Parameters:
- LIVES, 3, lives loaded at start/restart (1..7)
- TIME_LIMIT, 300, level time in seconds (1..511)
- TICKS_PER_SEC, 60, frame ticks per second
- INVULN_TICKS, 120, frame ticks of hit immunity after losing a life
- KEY_START, 8'h29, scancode for start (space)
- KEY_RESTART, 8'h2D, scancode for restart (R)
- KEY_PAUSE, 8'h4D, scancode for pause (P), used only with PAUSE_KEY_EN

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- state  in  2  state_fsm output: 00 IDLE, 01 PLAY, 10 OVER, 11 SUCCESS
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  8  make-code scancode
- tick  in  1  one-cycle frame strobe
- hit  in  1  enemy collision, level
- fall  in  1  pit fall, one-cycle pulse
- goal  in  1  flag reached, level
- start  out  1  start request
- restart  out  1  restart request
- over  out  1  game-over request
- success  out  1  level-complete request
- lives  out  3  remaining lives
- time_left  out  9  remaining seconds
- invuln  out  1  immunity window active
- paused  out  1  pause active

Behaviour:
- Reset, synchronous, active-high, dominates everything:
  - start, restart, over, success, invuln, paused = 0
  - lives = LIVES, time_left = TIME_LIMIT
  - tick prescaler = 0, immunity counter = 0
  - Reset mid-game clears all pending requests immediately.
- Request handshake, level req / state ack. Each request rises on the cycle after its trigger, holds until `state` shows the target, then drops the cycle after.
  - start: trigger key_valid && key_code==KEY_START while state==IDLE; ack state==PLAY.
  - restart: trigger KEY_RESTART while state==OVER or SUCCESS; ack state==IDLE.
  - over, success: triggered in PLAY as below; ack state==OVER / SUCCESS respectively.
  - At most one request is high at any time. New triggers are ignored while any request is pending.
  - Keys in any other state are ignored.
- Internal FSM:
  - WAIT: state IDLE/OVER/SUCCESS, or request pending.
  - RUN: state==PLAY, no request pending.
  - Entering RUN from start-ack reloads lives=LIVES, time_left=TIME_LIMIT, prescaler=0, immunity=0.
  - Restart-ack also reloads the same values.
- Timer (RUN only):
  - tick increments the prescaler.
  - When prescaler==TICKS_PER_SEC-1: prescaler wraps to 0 and time_left decrements.
  - When time_left would go 1->0: time_left=0 and assert over.
  - time_left never underflows and freezes outside RUN.
- Lives (RUN only):
  - A fall pulse, or a rising edge of hit while invuln==0, costs one life.
  - If lives==1: lives->0 and assert over.
  - Otherwise: lives-1, invuln=1, immunity counter=INVULN_TICKS.
  - Each tick decrements the immunity counter; invuln drops on reaching 0.
  - fall ignores invuln.
- Priority within one RUN cycle: goal > life loss > timer expiry.
  - goal asserts success; lives and time_left hold.
  - Simultaneous fall and hit cost one life only.
- Outputs are registered; trigger-to-request latency is 1 cycle.

Optional Feature:
- Macro `PAUSE_KEY_EN`.
- When defined:
  - KEY_PAUSE in RUN toggles paused.
  - While paused: tick, hit, fall and goal are ignored; the timer and immunity counter freeze; KEY_RESTART still has no effect.
  - paused clears on leaving PLAY or on reset.
- When undefined: paused is tied 0, KEY_PAUSE is treated as an ordinary ignored key, and no pause logic is synthesised.

Test Plan:
1. Reset, state=00, send key 8'h29 → start=1 next cycle. Drive state=01 → start=0 the following cycle; lives=3, time_left=300.
2. In PLAY with TICKS_PER_SEC=2, TIME_LIMIT=2, send 4 ticks → time_left 2→1→0. over=1 after the 4th tick, held until state=10, then cleared.
3. hit pulse → lives=2, invuln=1. Second hit within 120 ticks → lives stays 2. fall → lives=1. fall → lives=0, over=1.
4. goal, hit and fall in the same cycle at lives=1 → success=1, over=0, lives=1. Then state=11, key 8'h2D → restart=1; state=00 → restart=0, lives=3.
5. start pending (state held 00), assert rst → start=0, lives=3, time_left=300. Key 8'h2D in IDLE → no request.
6. With PAUSE_KEY_EN: key 8'h4D in PLAY → paused=1, ticks and hits ignored (time_left, lives unchanged). 8'h4D again → paused=0. Without the macro → paused stays 0.
